cdm8_74_mult: RTL and testbench

//   8x8 unsigned carry-disregard approximate multiplier with a registered result.
//   The low APPROX_COLS product columns are OR-compressed: they produce no carries.
//   The upper columns are summed exactly.

---
 rtl/cdm_pkg.sv | 19 +
 rtl/cdm_pp_matrix.sv | 68 ++++++
 rtl/cdm8_74_mult.sv | 50 +++++
 tb/tb_cdm8_74_mult.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdm_pkg
// Description : Shared constants for the carry-disregard approximate
//               multiplier: operand width, product width and the default
//               number of carry-free LSB columns.
// Revision    : 1.0  initial release
// ============================================================================
package cdm_pkg;

    // Operand width and full product width.
    localparam int W  = 8;
    localparam int PW = 2 * W;

    // Default number of LSB product columns that are OR-compressed.
    localparam int APPROX_COLS_DEFAULT = 7;

endpackage : cdm_pkg
`default_nettype wire

// File: rtl/cdm_pp_matrix.sv
`default_nettype none
// ============================================================================
// Module      : cdm_pp_matrix
// Description : Combinational partial-product matrix for an unsigned W x W
//               carry-disregard multiplier.
//               - Columns below APPROX_COLS: OR of the column's partial
//                 products, producing no carries.
//               - Columns at/above APPROX_COLS: exact sum through an adder
//                 tree of shifted rows masked to the high region.
// Ports       : i_a       [W-1:0]   multiplicand
//               i_b       [W-1:0]   multiplier
//               o_product [PW-1:0]  approximate product (combinational)
// Revision    : 1.0  initial release
// ============================================================================
module cdm_pp_matrix
    import cdm_pkg::*;
#(
    parameter int APPROX_COLS = APPROX_COLS_DEFAULT
) (
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    output logic [PW-1:0] o_product
);

    // Ones in every column at or above APPROX_COLS.
    localparam logic [PW-1:0] c_HIGH_MASK = {PW{1'b1}} << APPROX_COLS;

    logic [PW-1:0] w_row [W];
    logic [PW-1:0] w_sum_l1 [W/2];
    logic [PW-1:0] w_sum_l2 [W/4];
    logic [PW-1:0] w_high;
    logic [PW-1:0] w_low;

    // Row i is A shifted to weight 2^i, gated by B[i]. Masking drops the
    // low-region bits so they can never generate a carry into the high sum.
    for (genvar i = 0; i < W; i++) begin : g_row
        assign w_row[i] = (PW'(i_a) << i) & {PW{i_b[i]}} & c_HIGH_MASK;
    end

    // Balanced three-level adder tree (W = 8 rows). The exact product is
    // below 2^PW, so the masked sum cannot overflow PW bits.
    for (genvar k = 0; k < W/2; k++) begin : g_sum_l1
        assign w_sum_l1[k] = w_row[2*k] + w_row[2*k+1];
    end

    for (genvar k = 0; k < W/4; k++) begin : g_sum_l2
        assign w_sum_l2[k] = w_sum_l1[2*k] + w_sum_l1[2*k+1];
    end

    assign w_high = w_sum_l2[0] + w_sum_l2[1];

    // Low region: each column is the OR of its partial products.
    always_comb begin
        w_low = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                if ((i + j) < APPROX_COLS) begin
                    w_low[i+j] = w_low[i+j] | (i_a[i] & i_b[j]);
                end
            end
        end
    end

    // The two regions occupy disjoint bit ranges, so OR merges them.
    assign o_product = w_high | w_low;

endmodule : cdm_pp_matrix
`default_nettype wire

// File: rtl/cdm8_74_mult.sv
`default_nettype none
// ============================================================================
// Module      : cdm8_74_mult
// Description : 8x8 unsigned carry-disregard approximate multiplier with a
//               registered result. Latency 1 cycle, throughput 1 per cycle.
//               APPROX_COLS = 0 gives an exact multiplier (legal 0..15).
// Ports       : clk    rising-edge clock
//               rst_n  asynchronous active-low reset, clears R
//               A      [7:0]   unsigned multiplicand
//               B      [7:0]   unsigned multiplier
//               R      [15:0]  registered approximate product
// Revision    : 1.0  initial release
// ============================================================================
module cdm8_74_mult
    import cdm_pkg::*;
#(
    parameter int APPROX_COLS = APPROX_COLS_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  A,
    input  logic [W-1:0]  B,
    output logic [PW-1:0] R
);

    logic [PW-1:0] w_product;
    logic [PW-1:0] r_product;

    cdm_pp_matrix #(
        .APPROX_COLS (APPROX_COLS)
    ) u_pp_matrix (
        .i_a       (A),
        .i_b       (B),
        .o_product (w_product)
    );

    // The output register is the only state; reset discards any in-flight
    // product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_product <= '0;
        end else begin
            r_product <= w_product;
        end
    end

    assign R = r_product;

endmodule : cdm8_74_mult
`default_nettype wire

// File: tb/tb_cdm8_74_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdm8_74_mult
// Description : Self-checking bench for cdm8_74_mult. Expected products come
//               from a column-count reference model; inputs change on the
//               falling edge and R is sampled on the following falling edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cdm8_74_mult;

    localparam int AC = 7;

    logic        clk;
    logic        rst_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] R;

    int checks;
    int errors;

    cdm8_74_mult #(
        .APPROX_COLS (AC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .R     (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count the partial products that land in each column, then
    // OR-compress (any non-zero count -> 1) below AC and weight exactly above.
    function automatic int ref_mult(input int a, input int b);
        int cnt [16];
        int res;
        for (int c = 0; c < 16; c++) cnt[c] = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (((a >> i) & 1) == 1 && ((b >> j) & 1) == 1)
                    cnt[i+j] = cnt[i+j] + 1;
        res = 0;
        for (int c = 0; c < 16; c++) begin
            if (c < AC) begin
                if (cnt[c] > 0) res = res + (1 << c);
            end else begin
                res = res + cnt[c] * (1 << c);
            end
        end
        return res;
    endfunction

    function automatic int popcount8(input int v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n = n + ((v >> i) & 1);
        return n;
    endfunction

    // Apply one operand pair and check R one cycle later against a fixed value.
    task automatic apply_check(input string name, input int a, input int b, input int exp);
        @(negedge clk);
        A = 8'(a);
        B = 8'(b);
        @(negedge clk);
        checks++;
        if (int'(R) !== exp) begin
            errors++;
            $display("FAIL %s: A=%0d B=%0d R=%0d expected %0d", name, a, b, R, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        A = 8'd255;
        B = 8'd255;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (R !== 16'd0) begin
            errors++;
            $display("FAIL reset_hold: R=%0d expected 0", R);
        end
        rst_n = 1'b1;
        checks++;
        if (R !== 16'd0) begin
            errors++;
            $display("FAIL reset_release: R=%0d expected 0", R);
        end
        @(negedge clk);
        checks++;
        if (R !== 16'd64383) begin
            errors++;
            $display("FAIL reset_first_edge: R=%0d expected 64383", R);
        end
    endtask

    task automatic test_zero();
        apply_check("zero_a", 0, 173, 0);
        apply_check("zero_b", 173, 0, 0);
    endtask

    task automatic test_single_bit();
        apply_check("single_1x200", 1, 200, 200);
        apply_check("single_128x128", 128, 128, 16384);
        apply_check("single_200x4", 200, 4, 800);
    endtask

    task automatic test_carry_disregard();
        apply_check("cd_3x3", 3, 3, 7);
        apply_check("cd_15x15", 15, 15, 127);
        apply_check("max_255x255", 255, 255, 64383);
    endtask

    // Accuracy bounds that hold regardless of the model: never more than
    // exact + 2^AC - 1, and exact whenever an operand has at most one bit set.
    task automatic test_properties();
        int a, b, exact;
        for (int n = 0; n < 200; n++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            if (n % 4 == 0) a = (n % 16 == 0) ? 0 : (1 << (n % 8));
            @(negedge clk);
            A = 8'(a);
            B = 8'(b);
            @(negedge clk);
            exact = a * b;
            checks++;
            if (int'(R) > exact + (1 << AC) - 1) begin
                errors++;
                $display("FAIL prop_bound: A=%0d B=%0d R=%0d limit %0d", a, b, R, exact + (1 << AC) - 1);
            end
            if (popcount8(a) <= 1 || popcount8(b) <= 1) begin
                checks++;
                if (int'(R) !== exact) begin
                    errors++;
                    $display("FAIL prop_exact: A=%0d B=%0d R=%0d expected %0d", a, b, R, exact);
                end
            end
        end
    endtask

    // Exhaustive sweep, new operands every cycle in shuffled order, with an
    // asynchronous reset pulse that lands between clock edges mid-sweep.
    task automatic test_back_to_back();
        int order [65536];
        int tmp, k, prev_a, prev_b, cur_a, cur_b, exp, shown;
        bit have_prev;
        for (int i = 0; i < 65536; i++) order[i] = i;
        for (int i = 65535; i > 0; i--) begin
            k = int'($urandom_range(0, i));
            tmp = order[i];
            order[i] = order[k];
            order[k] = tmp;
        end
        have_prev = 1'b0;
        shown = 0;
        prev_a = 0;
        prev_b = 0;
        for (int i = 0; i <= 65536; i++) begin
            @(negedge clk);
            if (have_prev) begin
                exp = ref_mult(prev_a, prev_b);
                checks++;
                if (int'(R) !== exp) begin
                    errors++;
                    if (shown < 20) begin
                        shown++;
                        $display("FAIL sweep: A=%0d B=%0d R=%0d expected %0d", prev_a, prev_b, R, exp);
                    end
                end
            end
            if (i < 65536) begin
                cur_a = order[i] >> 8;
                cur_b = order[i] & 255;
                A = 8'(cur_a);
                B = 8'(cur_b);
                prev_a = cur_a;
                prev_b = cur_b;
                have_prev = 1'b1;
                if (i == 30000) begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    checks++;
                    if (R !== 16'd0) begin
                        errors++;
                        $display("FAIL sweep_async_reset: R=%0d expected 0", R);
                    end
                    #1;
                    rst_n = 1'b1;
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        A = 8'd0;
        B = 8'd0;
        test_reset();
        test_zero();
        test_single_bit();
        test_carry_disregard();
        test_properties();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cdm8_74_mult
`default_nettype wire
